// File: rtl/binary_decoder_scan.sv
// Registered N-to-2^N one-hot decoder: DIRECT decodes the address input,
// SCAN steps the one-hot position through every output with a prescaled dwell.
module binary_decoder_scan #(
  parameter int N          = 4,
  parameter int SCAN_DIV   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             en,
  input  logic [N-1:0]     a,
  output logic [(1<<N)-1:0] bcode,
  output logic [N-1:0]     idx,
  output logic             wrap
);

  localparam int W  = 1 << N;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};

  typedef enum logic {
    DIRECT = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic [N-1:0]  idx_reg, idx_next;
  logic          wrap_reg, wrap_next;
  logic [W-1:0]  bcode_reg, bcode_next;
  logic [W-1:0]  onehot_next;
  logic          act_next;
  logic [N-1:0]  act_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= DIRECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = mode ? SCAN : DIRECT;
  end

  // Everything downstream of the mode decision: which index (if any) is
  // driven next, and how the prescaler/index/wrap evolve.
  always_comb begin
    pre_next  = pre_reg;
    idx_next  = idx_reg;
    wrap_next = 1'b0;
    act_next  = 1'b0;
    act_idx   = idx_reg;
    if (!mode) begin
      pre_next = '0;
      if (en) begin
        act_next = 1'b1;
        act_idx  = a;
        idx_next = a;
      end
    end else if (state_reg == DIRECT) begin
      // Scan starts from the last decoded address with a fresh dwell.
      pre_next = '0;
      act_next = en;
    end else if (en) begin
      act_next = 1'b1;
      if (pre_reg == PRE_LAST) begin
        pre_next  = '0;
        idx_next  = idx_reg + N'(1);
        act_idx   = idx_reg + N'(1);
        wrap_next = (idx_reg == IDX_LAST);
      end else begin
        pre_next = pre_reg + PW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_dec
      assign onehot_next[gi] = act_next && (act_idx == N'(gi));
    end
  endgenerate

  assign bcode_next = onehot_next ^ INACTIVE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_reg   <= '0;
      idx_reg   <= '0;
      wrap_reg  <= 1'b0;
      bcode_reg <= INACTIVE;
    end else begin
      pre_reg   <= pre_next;
      idx_reg   <= idx_next;
      wrap_reg  <= wrap_next;
      bcode_reg <= bcode_next;
    end
  end

  assign bcode = bcode_reg;
  assign idx   = idx_reg;
  assign wrap  = wrap_reg;

endmodule

// File: doc/binary_decoder_scan.md
Name: binary_decoder_scan

Overview:
Parametrised, registered N-to-2^N binary decoder with two modes.
- DIRECT mode: decodes an external address into a one-hot output word.
- SCAN mode: an internal prescaled counter steps the one-hot output through every position. Used for display digit strobes and LED/row scanning.
- Replaces hand-built cascades of fixed-size combinational decoders in the display and I/O paths.

Parameters:
N, 4, address width; output width is 2^N; legal range 1..8.
SCAN_DIV, 4, clock cycles per scan step; legal range >=1.
ACTIVE_LOW, 0, 1 = output active level is 0 (inactive bits driven to 1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
mode  input  1  0 = DIRECT, 1 = SCAN; sampled every clock.
en  input  1  enable; 0 forces output inactive and freezes the scan.
a  input  N  address to decode in DIRECT mode.
bcode  output  2^N  registered one-hot decode, polarity per ACTIVE_LOW.
idx  output  N  index of the currently or last asserted output bit.
wrap  output  1  one-cycle pulse when the scan index wraps 2^N-1 -> 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Output encoding: "active(k)" means bit k is at the active level and all other bits are inactive. "inactive" means every bit is inactive: all 0, or all 1 when ACTIVE_LOW=1.
- Reset (rst_n=0 at a clk edge):
  - bcode = inactive; idx = 0; wrap = 0; prescaler = 0; state = DIRECT.
  - Reset takes priority over all other inputs, including mid-scan.
- State register: tracks the mode applied on the previous cycle (DIRECT or SCAN). Next state = mode.
- DIRECT (mode=0), per edge:
  - en=1: bcode <= active(a); idx <= a. Latency is one clock from a to bcode.
  - en=0: bcode <= inactive; idx holds.
  - prescaler <= 0; wrap <= 0.
- SCAN entry (mode=1 while state=DIRECT):
  - prescaler <= 0; idx holds, so scanning starts from the last decoded address.
  - bcode <= active(idx) if en=1, else inactive.
  - wrap <= 0.
- SCAN steady (mode=1, state=SCAN, en=1):
  - If prescaler == SCAN_DIV-1: prescaler <= 0; idx <= idx+1 modulo 2^N; bcode <= active(idx+1); wrap <= 1 iff idx == 2^N-1.
  - Otherwise: prescaler <= prescaler+1; bcode <= active(idx); wrap <= 0.
  - Each index is held exactly SCAN_DIV cycles.
- SCAN with en=0:
  - prescaler and idx freeze; bcode <= inactive; wrap <= 0.
  - On en returning to 1, counting resumes from the frozen prescaler value.
- SCAN -> DIRECT:
  - Takes effect on the next edge per the DIRECT rules.
  - prescaler cleared; any pending step is discarded.
- SCAN_DIV=1: the index advances every enabled cycle. The prescaler is a constant 0 and its width must be at least 1 bit.
- Widths:
  - prescaler width is clog2(SCAN_DIV), minimum 1.
  - idx increment wraps naturally at N bits.
  - For N=1, the output is 2 bits and wrap pulses on every second step.
- Invariant: bcode is either inactive or has exactly one bit at the active level. No glitching, because the output is fully registered.

Test Plan:
- Reset: N=4, ACTIVE_LOW=0. Hold rst_n=0 for 3 cycles with en=1, a=5 -> bcode=0x0000, idx=0, wrap=0. Release with DIRECT, en=1, a=5 -> bcode=0x0020, idx=5 on the next edge.
- Direct sweep: a=0..15, en=1 -> bcode=1<<a one cycle later. Drop en=0 -> bcode=0x0000 with idx held at 15. ACTIVE_LOW=1 build with a=3 -> bcode=0xFFF7.
- Scan stepping: N=4, SCAN_DIV=3. Direct a=14, then mode=1 ->
  - bcode=0x4000 for 3 cycles, then 0x8000 for 3, then 0x0001.
  - wrap=1 on exactly the cycle bcode becomes 0x0001.
  - Sequence repeats every 48 cycles.
- Freeze: mid-scan with idx=7 after 1 prescaler count, drop en for 5 cycles -> bcode=0x0000, idx=7. Restore en -> bcode=0x0080 for the remaining 2 cycles, then 0x0100.
- Mode switch and reset mid-scan:
  - SCAN at idx=9, set mode=0, a=2 -> bcode=0x0004 next edge.
  - Back to SCAN -> starts at idx=2 with a full SCAN_DIV dwell.
  - rst_n=0 mid-scan -> idx=0, bcode=0 next edge.
- Corners:
  - SCAN_DIV=1: bcode advances every cycle; wrap every 16 cycles.
  - N=1: outputs alternate 01, 10; wrap on each 1->0 index transition.
